// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operation sequencer.
// State encoding and the ALU function class codes live here so every file agrees on them.
package alu_seq_pkg;

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_RD_A   = 4'd1,
      S_WT_A   = 4'd2,
      S_RD_B   = 4'd3,
      S_WT_B   = 4'd4,
      S_EXEC   = 4'd5,
      S_WT_ALU = 4'd6,
      S_TX_LO  = 4'd7,
      S_TX_HI  = 4'd8
   } seq_state_t;

   // Upper two bits of the function code select the operation class.
   localparam logic [1:0] CLS_ARITH = 2'b00;
   localparam logic [1:0] CLS_LOGIC = 2'b01;
   localparam logic [1:0] CLS_CMP   = 2'b10;
   localparam logic [1:0] CLS_SHIFT = 2'b11;

endpackage

// File: rtl/seq_wait_timer.sv
// Wait-state cycle counter for the sequencer.
// Asserts expired during the wait cycle in which the count would reach TIMEOUT.
module seq_wait_timer #(
   parameter int TIMEOUT = 15
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_clr,
   input  logic i_run,
   output logic o_expired
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] MAX_CNT  = CW'(TIMEOUT);

   logic [CW-1:0] r_count;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_run && (r_count != MAX_CNT)) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_expired = i_run && (r_count == LAST_CNT);

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequences one ALU operation per command: read A and B, fire the ALU,
// then return the double-width result as two beats, low half first.
module alu_op_sequencer
   import alu_seq_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int A_ADDR     = 0,
   parameter int B_ADDR     = 1,
   parameter int TIMEOUT    = 15
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_cmd_valid,
   output logic                    o_cmd_ready,
   input  logic [3:0]              i_cmd_fun,
   output logic                    o_rf_rd_en,
   output logic [ADDR_WIDTH-1:0]   o_rf_addr,
   input  logic [DATA_WIDTH-1:0]   i_rf_rd_data,
   input  logic                    i_rf_rd_valid,
   output logic [DATA_WIDTH-1:0]   o_alu_a,
   output logic [DATA_WIDTH-1:0]   o_alu_b,
   output logic [3:0]              o_alu_fun,
   output logic                    o_alu_en,
   input  logic [2*DATA_WIDTH-1:0] i_alu_out,
   input  logic                    i_alu_out_vld,
   output logic                    o_res_valid,
   input  logic                    i_res_ready,
   output logic [DATA_WIDTH-1:0]   o_res_data,
   output logic                    o_busy,
   output logic                    o_err_timeout
);

   seq_state_t                r_state;
   logic                      r_rfRdEn;
   logic [ADDR_WIDTH-1:0]     r_rfAddr;
   logic [DATA_WIDTH-1:0]     r_aluA;
   logic [DATA_WIDTH-1:0]     r_aluB;
   logic [3:0]                r_aluFun;
   logic                      r_aluEn;
   logic [2*DATA_WIDTH-1:0]   r_result;
   logic                      r_resValid;
   logic [DATA_WIDTH-1:0]     r_resData;
   logic                      r_busy;
   logic                      r_errTimeout;

   logic w_timerClr;
   logic w_timerRun;
   logic w_expired;

   // Every wait state is entered from exactly one strobe state, so clearing there restarts the count.
   assign w_timerClr = (r_state == S_RD_A) || (r_state == S_RD_B) || (r_state == S_EXEC);
   assign w_timerRun = (r_state == S_WT_A) || (r_state == S_WT_B) || (r_state == S_WT_ALU);

   seq_wait_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_clr     (w_timerClr),
      .i_run     (w_timerRun),
      .o_expired (w_expired)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= S_IDLE;
         r_rfRdEn     <= 1'b0;
         r_rfAddr     <= '0;
         r_aluA       <= '0;
         r_aluB       <= '0;
         r_aluFun     <= '0;
         r_aluEn      <= 1'b0;
         r_result     <= '0;
         r_resValid   <= 1'b0;
         r_resData    <= '0;
         r_busy       <= 1'b0;
         r_errTimeout <= 1'b0;
      end else begin
         r_rfRdEn     <= 1'b0;
         r_aluEn      <= 1'b0;
         r_errTimeout <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_cmd_valid) begin
                  r_aluFun <= i_cmd_fun;
                  r_rfRdEn <= 1'b1;
                  r_rfAddr <= ADDR_WIDTH'(A_ADDR);
                  r_busy   <= 1'b1;
                  r_state  <= S_RD_A;
               end
            end
            S_RD_A: r_state <= S_WT_A;
            S_WT_A: begin
               if (i_rf_rd_valid) begin
                  r_aluA   <= i_rf_rd_data;
                  r_rfRdEn <= 1'b1;
                  r_rfAddr <= ADDR_WIDTH'(B_ADDR);
                  r_state  <= S_RD_B;
               end else if (w_expired) begin
                  r_errTimeout <= 1'b1;
                  r_busy       <= 1'b0;
                  r_state      <= S_IDLE;
               end
            end
            S_RD_B: r_state <= S_WT_B;
            S_WT_B: begin
               if (i_rf_rd_valid) begin
                  r_aluB  <= i_rf_rd_data;
                  r_aluEn <= 1'b1;
                  r_state <= S_EXEC;
               end else if (w_expired) begin
                  r_errTimeout <= 1'b1;
                  r_busy       <= 1'b0;
                  r_state      <= S_IDLE;
               end
            end
            S_EXEC: r_state <= S_WT_ALU;
            S_WT_ALU: begin
               if (i_alu_out_vld) begin
                  r_result   <= i_alu_out;
                  r_resValid <= 1'b1;
                  r_resData  <= i_alu_out[DATA_WIDTH-1:0];
                  r_state    <= S_TX_LO;
               end else if (w_expired) begin
                  r_errTimeout <= 1'b1;
                  r_busy       <= 1'b0;
                  r_state      <= S_IDLE;
               end
            end
            S_TX_LO: begin
               if (i_res_ready) begin
                  r_resData <= r_result[2*DATA_WIDTH-1:DATA_WIDTH];
                  r_state   <= S_TX_HI;
               end
            end
            S_TX_HI: begin
               if (i_res_ready) begin
                  r_resValid <= 1'b0;
                  r_busy     <= 1'b0;
                  r_state    <= S_IDLE;
               end
            end
            default: begin
               r_resValid <= 1'b0;
               r_busy     <= 1'b0;
               r_state    <= S_IDLE;
            end
         endcase
      end
   end

   assign o_cmd_ready   = (r_state == S_IDLE);
   assign o_rf_rd_en    = r_rfRdEn;
   assign o_rf_addr     = r_rfAddr;
   assign o_alu_a       = r_aluA;
   assign o_alu_b       = r_aluB;
   assign o_alu_fun     = r_aluFun;
   assign o_alu_en      = r_aluEn;
   assign o_res_valid   = r_resValid;
   assign o_res_data    = r_resData;
   assign o_busy        = r_busy;
   assign o_err_timeout = r_errTimeout;

endmodule
